branch_predictor: RTL and testbench

- Parametrised next-PC predictor for the 5-stage RISC-V pipeline.
- Replaces the fixed "predict PC+4, flush on taken branch/jal/jalr in EX" scheme.
- IF queries it combinationally with the current PC. EX writes back the resolved outcome of every branch/jal/jalr.
- Contains a direct-mapped BTB, a saturating-counter pattern history table (PHT) and a mispredict statistics counter.

---
 rtl/branch_predictor.sv | 160 ++++++++++++++++
 tb/tb_branch_predictor.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: next-PC predictor for the 5-stage RISC-V pipeline.
//   Direct-mapped BTB (valid/tag/target/is_jump), saturating-counter PHT and a
//   saturating mispredict counter. Lookup is combinational; update is on the
//   rising edge when EX resolves a branch/jal/jalr.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   pred_pc               IF-stage PC for the lookup
//   pred_taken            lookup hit and predicted taken
//   pred_next_pc          predicted next fetch PC (target or pred_pc + 4)
//   upd_valid             EX resolves a control instruction this cycle
//   upd_pc                PC of the resolved instruction
//   upd_is_branch         1 = conditional branch, 0 = jal/jalr
//   upd_taken             resolved direction
//   upd_target            resolved target
//   upd_mispredict        EX saw a wrong prediction (qualified by upd_valid)
//   mispredict_count      saturating mispredict count
// Optional feature: define BRANCH_PREDICTOR_GSHARE_EN to XOR a non-speculative
// global history register into the PHT index.
module branch_predictor #(
  parameter int unsigned BTB_ENTRIES = 32,
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned CTR_BITS    = 2,
  parameter int unsigned GHR_BITS    = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] pred_pc,
  output logic                pred_taken,
  output logic [PC_WIDTH-1:0] pred_next_pc,
  input  logic                upd_valid,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic                upd_is_branch,
  input  logic                upd_taken,
  input  logic [PC_WIDTH-1:0] upd_target,
  input  logic                upd_mispredict,
  output logic [31:0]         mispredict_count
);

  localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = PC_WIDTH - IDX - 2;

  localparam logic [CTR_BITS-1:0] CTR_WT  = {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [CTR_BITS-1:0] CTR_WNT = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  logic                valid_q   [BTB_ENTRIES];
  logic                valid_d   [BTB_ENTRIES];
  logic [TAG_W-1:0]    tag_q     [BTB_ENTRIES];
  logic [TAG_W-1:0]    tag_d     [BTB_ENTRIES];
  logic [PC_WIDTH-1:0] target_q  [BTB_ENTRIES];
  logic [PC_WIDTH-1:0] target_d  [BTB_ENTRIES];
  logic                is_jump_q [BTB_ENTRIES];
  logic                is_jump_d [BTB_ENTRIES];
  logic [CTR_BITS-1:0] pht_q     [BTB_ENTRIES];
  logic [CTR_BITS-1:0] pht_d     [BTB_ENTRIES];
  logic [31:0]         cnt_q, cnt_d;

  logic [IDX-1:0]   lk_idx, lk_pht_idx, up_idx, up_pht_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;

  assign lk_idx = pred_pc[IDX+1:2];
  assign lk_tag = pred_pc[PC_WIDTH-1:IDX+2];
  assign up_idx = upd_pc[IDX+1:2];
  assign up_tag = upd_pc[PC_WIDTH-1:IDX+2];

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [GHR_BITS-1:0] ghr_q, ghr_d;

  // Update uses the history before this edge's shift, same as the lookup does.
  assign lk_pht_idx = lk_idx ^ IDX'(ghr_q);
  assign up_pht_idx = up_idx ^ IDX'(ghr_q);

  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid && upd_is_branch)
      ghr_d = (ghr_q << 1) | GHR_BITS'(upd_taken);
  end

  always_ff @(posedge clk) begin
    if (reset) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end
`else
  logic [GHR_BITS-1:0] unused_ghr;
  assign unused_ghr = '0;
  assign lk_pht_idx = lk_idx;
  assign up_pht_idx = up_idx;
`endif

  logic unused_pc_lsb;
  assign unused_pc_lsb = &{1'b0, upd_pc[1:0]};

  // Lookup: sees pre-update state when an update hits the same entry.
  assign lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken   = lk_hit && (is_jump_q[lk_idx] || pht_q[lk_pht_idx][CTR_BITS-1]);
  assign pred_next_pc = pred_taken ? target_q[lk_idx] : pred_pc + PC_WIDTH'(4);

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    valid_d   = valid_q;
    tag_d     = tag_q;
    target_d  = target_q;
    is_jump_d = is_jump_q;
    pht_d     = pht_q;
    cnt_d     = cnt_q;

    if (upd_valid) begin
      if (up_hit) begin
        if (upd_is_branch) begin
          if (upd_taken) begin
            if (pht_q[up_pht_idx] != CTR_MAX)
              pht_d[up_pht_idx] = pht_q[up_pht_idx] + CTR_BITS'(1);
          end else if (pht_q[up_pht_idx] != '0) begin
            pht_d[up_pht_idx] = pht_q[up_pht_idx] - CTR_BITS'(1);
          end
        end
        if (upd_taken)
          target_d[up_idx] = upd_target;
        is_jump_d[up_idx] = ~upd_is_branch;
      end else if (upd_taken) begin
        valid_d[up_idx]   = 1'b1;
        tag_d[up_idx]     = up_tag;
        target_d[up_idx]  = upd_target;
        is_jump_d[up_idx] = ~upd_is_branch;
        pht_d[up_pht_idx] = CTR_WT;
      end else if (pht_q[up_pht_idx] != '0) begin
        // Miss, not taken: no allocation, but the counter still trains down.
        pht_d[up_pht_idx] = pht_q[up_pht_idx] - CTR_BITS'(1);
      end

      if (upd_mispredict && (cnt_q != '1))
        cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i]   <= 1'b0;
        tag_q[i]     <= '0;
        target_q[i]  <= '0;
        is_jump_q[i] <= 1'b0;
        pht_q[i]     <= CTR_WNT;
      end
      cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      target_q  <= target_d;
      is_jump_q <= is_jump_d;
      pht_q     <= pht_d;
      cnt_q     <= cnt_d;
    end
  end

  assign mispredict_count = cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_branch;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [31:0] mispredict_count;

  branch_predictor #(
    .BTB_ENTRIES(32),
    .PC_WIDTH   (32),
    .CTR_BITS   (2),
    .GHR_BITS   (5)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pred_pc         (pred_pc),
    .pred_taken      (pred_taken),
    .pred_next_pc    (pred_next_pc),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_is_branch   (upd_is_branch),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_mispredict  (upd_mispredict),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        taken;
    logic [31:0] next_pc;
    logic [31:0] count;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_cnt = 0;

  task automatic compare_now();
    exp_t e;
    e = sb.pop_front();
    n_cmp++;
    assert ({pred_taken, pred_next_pc} === {e.taken, e.next_pc})
    else begin
      n_err++;
      $error("FAIL %s pred: observed taken=%0b next=%h expected taken=%0b next=%h",
             e.name, pred_taken, pred_next_pc, e.taken, e.next_pc);
    end
    n_cmp++;
    assert (mispredict_count === e.count)
    else begin
      n_err++;
      $error("FAIL %s count: observed %0d expected %0d", e.name, mispredict_count, e.count);
    end
  endtask

  task automatic push_exp(input string name, input logic tk, input logic [31:0] nxt);
    exp_t e;
    e.name = name; e.taken = tk; e.next_pc = nxt; e.count = exp_cnt;
    sb.push_back(e);
  endtask

  task automatic expect_pred(input string name, input logic [31:0] pc,
                             input logic tk, input logic [31:0] nxt);
    pred_pc = pc;
    push_exp(name, tk, nxt);
    #2;
    compare_now();
  endtask

  task automatic upd(input logic [31:0] pc, input logic br, input logic tk,
                     input logic [31:0] tgt, input logic mp);
    upd_valid = 1'b1; upd_pc = pc; upd_is_branch = br;
    upd_taken = tk; upd_target = tgt; upd_mispredict = mp;
    @(posedge clk);
    #1;
    upd_valid = 1'b0; upd_mispredict = 1'b0;
    if (mp) exp_cnt++;
  endtask

  initial begin
    reset = 1'b1; pred_pc = 32'h40; upd_valid = 1'b0; upd_pc = '0;
    upd_is_branch = 1'b0; upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state and PC wrap
    expect_pred("reset_40", 32'h40, 1'b0, 32'h44);
    expect_pred("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

    // Allocate 0x40 taken -> weakly taken
    upd(32'h40, 1'b1, 1'b1, 32'h20, 1'b1);
    expect_pred("alloc_40", 32'h40, 1'b1, 32'h20);

    // Train down: 10 -> 01 -> 00 -> 00
    upd(32'h40, 1'b1, 1'b0, 32'h0, 1'b1);
    expect_pred("nt1", 32'h40, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 1'b0, 32'h0, 1'b0);
    upd(32'h40, 1'b1, 1'b0, 32'h0, 1'b0);
    // 00 -> 01 shows no wrap at 0
    upd(32'h40, 1'b1, 1'b1, 32'h20, 1'b0);
    expect_pred("sat0", 32'h40, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 1'b1, 32'h20, 1'b1);
    expect_pred("t2", 32'h40, 1'b1, 32'h20);
    upd(32'h40, 1'b1, 1'b1, 32'h20, 1'b0);
    upd(32'h40, 1'b1, 1'b1, 32'h28, 1'b0);  // saturated at 11, new target
    upd(32'h40, 1'b1, 1'b0, 32'h0, 1'b1);   // 11 -> 10
    expect_pred("sat3_nt1", 32'h40, 1'b1, 32'h28);
    upd(32'h40, 1'b1, 1'b0, 32'h0, 1'b0);   // 10 -> 01
    expect_pred("sat3_nt2", 32'h40, 1'b0, 32'h44);

    // Alias 0xC0 evicts 0x40
    upd(32'hC0, 1'b1, 1'b1, 32'h200, 1'b0);
    expect_pred("alias_40", 32'h40, 1'b0, 32'h44);
    expect_pred("alias_C0", 32'hC0, 1'b1, 32'h200);

    // Jump at 0x100, then branch not-taken clears is_jump
    upd(32'h100, 1'b0, 1'b1, 32'h8, 1'b1);
    expect_pred("jump", 32'h100, 1'b1, 32'h8);
    upd(32'h100, 1'b1, 1'b0, 32'h0, 1'b0);
    expect_pred("jump_to_br", 32'h100, 1'b0, 32'h104);

    // Same-cycle update and lookup at 0x40 (currently aliased out)
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = 32'h40; upd_is_branch = 1'b1;
    upd_taken = 1'b1; upd_target = 32'h20; upd_mispredict = 1'b1;
    pred_pc = 32'h40;
    push_exp("same_cycle_old", 1'b0, 32'h44);
    #1 compare_now();
    @(posedge clk);
    #1 upd_valid = 1'b0; upd_mispredict = 1'b0; exp_cnt++;
    expect_pred("same_cycle_new", 32'h40, 1'b1, 32'h20);

    // Reset mid-stream with a concurrent update: reset wins
    @(negedge clk);
    reset = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h100; upd_is_branch = 1'b0;
    upd_taken = 1'b1; upd_target = 32'h8; upd_mispredict = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0; exp_cnt = 0;
    expect_pred("rst_40", 32'h40, 1'b0, 32'h44);
    expect_pred("rst_C0", 32'hC0, 1'b0, 32'hC4);
    expect_pred("rst_100", 32'h100, 1'b0, 32'h104);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
